// File: rtl/data_memory_bytelane.sv
// Word-organised data memory with RV32I byte/half/word load-store lanes,
// a fixed number of wait cycles per legal access and a one-cycle response strobe.
module data_memory_bytelane #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_write;
    logic [2:0]    w_funct3;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic          w_legal;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic          w_exec;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [3:0]    w_wmask;
    logic [31:0]   w_lanes;

    // In IDLE the live request is decoded (zero-wait accesses execute on the
    // acceptance edge); otherwise the captured request drives the datapath.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_write  = req_write;
            w_funct3 = req_funct3;
            w_addr   = req_addr;
            w_wdata  = req_wdata;
        end else begin
            w_write  = r_write;
            w_funct3 = r_funct3;
            w_addr   = r_addr;
            w_wdata  = r_wdata;
        end
    end

    always_comb begin
        if (w_write) begin
            w_legal = w_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_legal = w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (w_funct3[1:0])
            2'b01:   w_misalign = w_addr[0];
            2'b10:   w_misalign = (w_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
        w_oor = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
        w_err = !w_legal || w_misalign || w_oor;
    end

    assign w_idx  = w_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_exec = rst_n && (((r_state == S_IDLE) && req_valid && !w_err && (LP_WAIT == 4'd0))
                           || ((r_state == S_WAIT) && (r_count == 4'd1)));

    always_comb begin
        w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'h000000, w_byte};
            3'b101:  w_load = {16'h0000, w_half};
            default: w_load = 32'h00000000;
        endcase
    end

    // Store data is replicated across lanes so the mask alone picks the target bytes.
    always_comb begin
        case (w_funct3[1:0])
            2'b00: begin
                w_wmask = 4'b0001 << w_addr[1:0];
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_wmask = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_wmask = 4'b1111;
                w_lanes = w_wdata;
            end
        endcase
    end

    // Memory has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_exec && w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h00000000;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h00000000;
                        end else if (LP_WAIT == 4'd0) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= req_write ? 32'h00000000 : w_load;
                        end else begin
                            r_state <= S_WAIT;
                            r_count <= LP_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_write ? 32'h00000000 : w_load;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'h00000000;
                    r_resp_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && rst_n;
    assign busy       = !req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: three instances (WAIT_CYCLES 1, 3, 0) checked
// against a byte-array reference model with directed and randomized accesses.
module tb_data_memory_bytelane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0]       req_write;
    logic [2:0][2:0]  req_funct3;
    logic [2:0][31:0] req_addr;
    logic [2:0][31:0] req_wdata;
    logic [2:0]       resp_valid;
    logic [2:0][31:0] resp_rdata;
    logic [2:0]       resp_err;
    logic [2:0]       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [3][1024];

    data_memory_bytelane #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0]));

    data_memory_bytelane #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1]));

    data_memory_bytelane #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]), .busy(busy[2]));

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : ((k == 1) ? 64 : 16);
    endfunction

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic logic model_err(input int k, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic legal;
        logic mis;
        logic oor;
        int   size;
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = 1 << f3[1:0];
        mis  = ((size == 2) && (a % 2 != 0)) || ((size == 4) && (a % 4 != 0));
        oor  = (longint'(a) / 4) >= longint'(depth_of(k));
        return !legal || mis || oor;
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [2:0] f3,
                                               input logic [31:0] a);
        int          i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a);
        b = mm[k][i];
        h = {mm[k][(i + 1) % 1024], mm[k][i]};
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd1: return {{16{h[15]}}, h};
            3'd2: return {mm[k][(i + 3) % 1024], mm[k][(i + 2) % 1024], h};
            3'd4: return {24'h0, b};
            3'd5: return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input int k, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int j = 0; j < n; j++) mm[k][int'(a) + j] = wd[8*j +: 8];
    endtask

    // Drives one request from idle and reports what the DUT did with it.
    task automatic do_req(input int k, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic rdy, output int lat, output logic [31:0] rd,
                          output logic er, output logic post_v, output logic [31:0] post_rd,
                          output logic post_er);
        @(negedge clk);
        rdy           = req_ready[k];
        req_valid[k]  = 1'b1;
        req_write[k]  = wr;
        req_funct3[k] = f3;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (resp_valid[k] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata[k];
        er = resp_err[k];
        @(posedge clk);
        #1;
        post_v  = resp_valid[k];
        post_rd = resp_rdata[k];
        post_er = resp_err[k];
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 3'b000;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (req_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL reset_ready[%0d]: ready=%b busy=%b required ready=0 busy=1",
                             k, req_ready[k], busy[k]);
                end
                checks++;
                if (resp_valid[k] !== 1'b0 || resp_rdata[k] !== 32'h0 || resp_err[k] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_resp[%0d]: valid=%b rdata=%h err=%b required 0/0/0",
                             k, resp_valid[k], resp_rdata[k], resp_err[k]);
                end
            end
        end
        @(negedge clk);
        rst_n = 3'b111;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_ready[%0d]: ready=%b busy=%b required ready=1 busy=0",
                         k, req_ready[k], busy[k]);
            end
        end
    endtask

    task automatic test_init();
        logic rdy, er, pv, pe;
        logic [31:0] rd, prd, wd;
        int lat;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                do_req(k, 1'b1, 3'd2, 32'(4 * w), wd, rdy, lat, rd, er, pv, prd, pe);
                model_store(k, 3'd2, 32'(4 * w), wd);
                checks++;
                if (rdy !== 1'b1 || lat != wait_of(k) + 1 || rd !== 32'h0 || er !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL init_sw[%0d] w%0d: ready=%b lat=%0d rdata=%h err=%b required 1/%0d/0/0",
                             k, w, rdy, lat, rd, er, wait_of(k) + 1);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic        wr_t [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f3_t [10] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd1, 3'd5, 3'd2};
        logic [31:0] a_t  [10] = '{32'h8, 32'h8, 32'h9, 32'h9, 32'h9, 32'h8, 32'hA, 32'hA, 32'hA, 32'h8};
        logic [31:0] wd_t [10] = '{32'hDEADBEEF, 32'h0, 32'h000000F0, 32'h0, 32'h0, 32'h0,
                                   32'h00008001, 32'h0, 32'h0, 32'h0};
        logic [31:0] ex_t [10] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFFF0, 32'h000000F0,
                                   32'hDEADF0EF, 32'h0, 32'hFFFF8001, 32'h00008001, 32'h8001F0EF};
        logic rdy, er, pv, pe;
        logic [31:0] rd, prd;
        int lat;
        for (int i = 0; i < 10; i++) begin
            do_req(0, wr_t[i], f3_t[i], a_t[i], wd_t[i], rdy, lat, rd, er, pv, prd, pe);
            if (wr_t[i]) model_store(0, f3_t[i], a_t[i], wd_t[i]);
            checks++;
            if (rdy !== 1'b1 || lat != 2) begin
                errors++;
                $display("[TB] FAIL directed_latency #%0d: ready=%b lat=%0d required 1/2", i, rdy, lat);
            end
            checks++;
            if (rd !== ex_t[i] || er !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_data #%0d: rdata=%h err=%b required %h/0", i, rd, er, ex_t[i]);
            end
            checks++;
            if (pv !== 1'b0 || prd !== 32'h0 || pe !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_resp_one_cycle #%0d: valid=%b rdata=%h err=%b required 0/0/0",
                         i, pv, prd, pe);
            end
        end
    endtask

    task automatic test_errors();
        logic        wr_t [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3_t [7] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd2, 3'd0, 3'd2};
        logic [31:0] a_t  [7] = '{32'h6, 32'h5, 32'h0, 32'h4, 32'h400, 32'h401, 32'hFFFFFFFC};
        logic rdy, er, pv, pe;
        logic [31:0] rd, prd;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_req(0, wr_t[i], f3_t[i], a_t[i], 32'hA5A5A5A5, rdy, lat, rd, er, pv, prd, pe);
            checks++;
            if (rdy !== 1'b1 || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("[TB] FAIL error_req #%0d: ready=%b lat=%0d err=%b rdata=%h required 1/1/1/0",
                         i, rdy, lat, er, rd);
            end
        end
        do_req(0, 1'b0, 3'd2, 32'h4, 32'h0, rdy, lat, rd, er, pv, prd, pe);
        checks++;
        if (rd !== model_load(0, 3'd2, 32'h4) || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_no_write: rdata=%h err=%b required %h/0",
                     rd, er, model_load(0, 3'd2, 32'h4));
        end
    endtask

    task automatic test_random(input int k, input int n);
        logic        wr, rdy, er, pv, pe, eerr;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, prd, exp_rd;
        int          lat, exp_lat;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'(depth_of(k) * 4) + 32'($urandom_range(0, 63));
            else                           a = 32'($urandom_range(0, 63));
            eerr    = model_err(k, wr, f3, a);
            exp_rd  = (eerr || wr) ? 32'h0 : model_load(k, f3, a);
            exp_lat = eerr ? 1 : wait_of(k) + 1;
            do_req(k, wr, f3, a, wd, rdy, lat, rd, er, pv, prd, pe);
            if (!eerr && wr) model_store(k, f3, a, wd);
            checks++;
            if (rdy !== 1'b1 || lat != exp_lat || rd !== exp_rd || er !== eerr || pv !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random[%0d] #%0d wr=%b f3=%0d a=%h: lat=%0d rdata=%h err=%b post=%b required lat=%0d rdata=%h err=%b post=0",
                         k, i, wr, f3, a, lat, rd, er, pv, exp_lat, exp_rd, eerr);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic rdy, er, pv, pe, seen;
        logic [31:0] rd, prd, exp_old;
        int lat;
        exp_old = model_load(1, 3'd2, 32'h10);
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b1;
        req_funct3[1] = 3'd2;
        req_addr[1]   = 32'h10;
        req_wdata[1]  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy: busy=%b required 1", busy[1]);
        end
        @(negedge clk);
        rst_n[1] = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (resp_valid[1] === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid[1] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_resp: resp_valid seen=%b required 0", seen);
        end
        do_req(1, 1'b0, 3'd2, 32'h10, 32'h0, rdy, lat, rd, er, pv, prd, pe);
        checks++;
        if (rdy !== 1'b1 || lat != 4 || rd !== exp_old || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_write: ready=%b lat=%0d rdata=%h err=%b required 1/4/%h/0",
                     rdy, lat, rd, er, exp_old);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        int acc [4];
        int i, last, got, cyc;
        for (int j = 0; j < 4; j++) a[j] = 32'(4 * $urandom_range(0, 15));
        i = 0; last = 0; got = 0; cyc = 0;
        @(negedge clk);
        req_valid[2]  = 1'b1;
        req_write[2]  = 1'b0;
        req_funct3[2] = 3'd2;
        req_addr[2]   = a[0];
        while ((i < 4 || got < 4) && cyc < 40) begin
            if (resp_valid[2] === 1'b1) begin
                got++;
                checks++;
                if (req_ready[2] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_ready_in_resp: ready=%b required 0", req_ready[2]);
                end
                checks++;
                if (resp_rdata[2] !== model_load(2, 3'd2, a[last])) begin
                    errors++;
                    $display("[TB] FAIL b2b_data #%0d: rdata=%h required %h",
                             last, resp_rdata[2], model_load(2, 3'd2, a[last]));
                end
            end
            if (req_ready[2] === 1'b1 && i < 4) begin
                acc[i] = cyc;
                last = i;
                i++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (i < 4) req_addr[2] = a[i];
            else       req_valid[2] = 1'b0;
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        checks++;
        if (got != 4 || i != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: accepted=%0d responses=%0d required 4/4", i, got);
        end
        for (int j = 1; j < i; j++) begin
            checks++;
            if (acc[j] - acc[j-1] != 2) begin
                errors++;
                $display("[TB] FAIL b2b_spacing #%0d: gap=%0d required 2", j, acc[j] - acc[j-1]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 3'b000;
        req_valid  = '0;
        req_write  = '0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        test_reset();
        test_init();
        test_directed();
        test_errors();
        test_random(0, 40);
        test_random(1, 30);
        test_random(2, 40);
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_bytelane.md
DATA_MEMORY_BYTELANE -- requirements
Module: data_memory_bytelane

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, number of extra access cycles (0..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  synchronous active-low reset.
REQ-006 Port: req_valid  input  1  request present.
REQ-007 Port: req_ready  output  1  block can accept a request.
REQ-008 Port: req_write  input  1  1 = store, 0 = load.
REQ-009 Port: req_funct3  input  3  RV32I load/store funct3 encoding.
REQ-010 Port: req_addr  input  32  byte address.
REQ-011 Port: req_wdata  input  32  store data, right-aligned (byte/half in low bits).
REQ-012 Port: resp_valid  output  1  one-cycle response strobe.
REQ-013 Port: resp_rdata  output  32  load result, extended to 32 bits.
REQ-014 Port: resp_err  output  1  request rejected (misaligned, illegal funct3, out of range).
REQ-015 Port: busy  output  1  request in flight; stalls the pipeline.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = (state==IDLE) AND rst_n; busy = NOT req_ready.
REQ-017 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; write, funct3, addr and wdata are captured then.
REQ-018 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; any other combination is illegal.
REQ-019 Misalignment: half access with addr[0]=1; word access with addr[1:0]!=0; byte access is never misaligned.
REQ-020 Out of range: addr[31:2] >= DEPTH_WORDS.
REQ-021 An erroneous request SHALL go IDLE->RESP directly, leave memory unchanged, and return resp_err=1, resp_rdata=0.
REQ-022 A legal request SHALL go IDLE->RESP when WAIT_CYCLES=0, else IDLE->WAIT with counter loaded to WAIT_CYCLES.
REQ-023 In WAIT the counter SHALL decrement each cycle; at the edge where it equals 1, the access executes and the state becomes RESP.
REQ-024 Legal latency SHALL be exactly WAIT_CYCLES+1 cycles from acceptance edge to resp_valid high; error latency SHALL be 1 cycle.
REQ-025 RESP SHALL last exactly one cycle (resp_valid=1), then return to IDLE; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-026 Byte lanes SHALL be little-endian: byte n of word sits at bits [8n+7:8n], selected by addr[1:0].
REQ-027 SB SHALL write only lane addr[1:0] with wdata[7:0]; SH only lanes addr[1]*2 and +1 with wdata[15:0]; SW all lanes; other lanes unchanged.
REQ-028 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW returns the word unmodified.
REQ-029 Load data SHALL be the memory content at the execute edge; stores return resp_rdata=0, resp_err=0.
REQ-030 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-031 Requests presented while req_ready=0 SHALL be ignored; the requester holds them.
REQ-032 Memory contents SHALL be uninitialised by RTL and SHALL NOT be cleared by reset.

Reset
REQ-033 rst_n=0 at a rising edge SHALL force state IDLE, counter 0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-034 Reset sampled in WAIT SHALL abort the pending access: no memory write, no response.
REQ-035 While rst_n=0, req_ready SHALL be 0 and busy 1; no request is accepted.

Verification
REQ-036 WAIT_CYCLES=1: SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> each resp_valid 2 cycles after acceptance, load returns 0xDEADBEEF.
REQ-037 After REQ-036: SB addr 0x9 data 0x000000F0, LB 0x9 -> 0xFFFFFFF0; LBU 0x9 -> 0x000000F0; LW 0x8 -> 0xDEADF0EF.
REQ-038 SH 0xA data 0x8001, then LH 0xA -> 0xFFFF8001, LHU 0xA -> 0x00008001, LW 0x8 -> 0x8001F0EF.
REQ-039 LW 0x6, SH 0x5, funct3 011, addr 4*DEPTH_WORDS -> resp_err=1 one cycle after acceptance, resp_rdata=0, LW 0x4 unchanged.
REQ-040 WAIT_CYCLES=3: SW 0x10 data 0x12345678, rst_n low two cycles after acceptance -> no resp_valid; LW 0x10 returns prior contents.
REQ-041 WAIT_CYCLES=0: req_valid held high with 4 loads -> one acceptance every 2 cycles, req_ready low during RESP.
